// File: rtl/sti_loader.sv
// sti_loader -- unpacks a 128x128 binary image stored as 1024 x 16-bit ROM
// words into 16384 byte pixels in a result RAM, forcing the one-pixel border
// of the image to zero.
//
// Ports
//   clk       : single clock, all state changes on the rising edge
//   reset     : asynchronous, active-low reset
//   start     : begin one image load (only looked at while IDLE)
//   busy      : high while words are being read and written (READ/WRITE)
//   done      : level, set when the last pixel has been written, cleared
//               when the next start is accepted
//   sti_rd    : ROM read strobe (ROM samples it on the falling edge)
//   sti_addr  : ROM word address
//   sti_di    : ROM data, valid on the rising edge that ends READ
//   res_wr    : RAM write strobe (RAM writes on the rising edge)
//   res_addr  : RAM pixel address {row[6:0], column[6:0]}
//   res_do    : pixel value, 8'h00 or 8'h01
//   fg_cnt    : number of foreground pixels written (only with FG_COUNT_EN)
//
// Build option
//   FG_COUNT_EN : when defined, adds the fg_cnt port and its counter.
//
// Strobe protocol: there is no back-pressure. sti_rd is high for exactly the
// one READ cycle of each word and the ROM word arrives by the end of that
// cycle; res_wr is high for each of the 16 WRITE cycles that follow, one
// pixel per cycle, and the RAM must accept every write. The two strobes are
// never high in the same cycle.
//
// The FSM state is held in state_q, which checkers may bind to directly.

module sti_loader (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        sti_rd,
    output logic [9:0]  sti_addr,
    input  logic [15:0] sti_di,
    output logic        res_wr,
    output logic [13:0] res_addr,
    output logic [7:0]  res_do
`ifdef FG_COUNT_EN
    ,
    output logic [13:0] fg_cnt
`endif
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        READ   = 2'd1,
        WRITE  = 2'd2,
        FINISH = 2'd3
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic [9:0]  w_q;       // current ROM word
    logic [3:0]  k_q;       // pixel index within the word during WRITE
    logic [15:0] word_q;    // captured ROM word
    logic        done_q;

    logic        accept;    // start taken this cycle
    logic        word_end;  // last pixel of the current word
    logic        last_word;
    logic [6:0]  row;
    logic [6:0]  col;
    logic        border;
    logic        pix;

    assign accept    = (state_q == IDLE) && start;
    assign word_end  = (state_q == WRITE) && (k_q == 4'd15);
    assign last_word = (w_q == 10'd1023);

    // Pixel address {w, k} splits as row = w[9:3], column = {w[2:0], k}.
    assign row    = w_q[9:3];
    assign col    = {w_q[2:0], k_q};
    assign border = (row == 7'd0) || (row == 7'd127) ||
                    (col == 7'd0) || (col == 7'd127);
    // Word MSB is the leftmost pixel, so pixel k uses bit 15-k.
    assign pix    = word_q[4'd15 - k_q] & ~border;

    // Next state and decoded outputs
    always_comb begin
        state_d  = state_q;
        busy     = 1'b0;
        sti_rd   = 1'b0;
        res_wr   = 1'b0;
        res_addr = 14'd0;
        res_do   = 8'h00;
        sti_addr = w_q;
        done     = done_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = READ;
                end
            end
            READ: begin
                busy    = 1'b1;
                sti_rd  = 1'b1;
                state_d = WRITE;
            end
            WRITE: begin
                busy     = 1'b1;
                res_wr   = 1'b1;
                res_addr = {w_q, k_q};
                res_do   = {7'd0, pix};
                if (k_q == 4'd15) begin
                    state_d = last_word ? FINISH : READ;
                end
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            w_q    <= 10'd0;
            k_q    <= 4'd0;
            word_q <= 16'd0;
            done_q <= 1'b0;
        end else begin
            if (accept) begin
                w_q    <= 10'd0;
                done_q <= 1'b0;
            end else if (word_end) begin
                // w stops at 1023 so no address past the image is formed.
                if (last_word) begin
                    done_q <= 1'b1;
                end else begin
                    w_q <= w_q + 10'd1;
                end
            end

            if (state_q == WRITE) begin
                k_q <= k_q + 4'd1;   // wraps to 0 after pixel 15
            end else begin
                k_q <= 4'd0;
            end

            if (state_q == READ) begin
                word_q <= sti_di;
            end
        end
    end

`ifdef FG_COUNT_EN
    logic [13:0] fg_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fg_q <= 14'd0;
        end else if (accept) begin
            fg_q <= 14'd0;
        end else if ((state_q == WRITE) && pix) begin
            fg_q <= fg_q + 14'd1;
        end
    end

    assign fg_cnt = fg_q;
`endif

endmodule

// File: tb/tb_sti_loader.sv
// Testbench for sti_loader. A ROM model answers read strobes, a reference
// model computes every expected RAM write from the image rules, and a
// monitor pops and compares each write and read as the DUT presents it.

module tb_sti_loader;

    logic        clk;
    logic        reset;
    logic        start;
    logic        busy;
    logic        done;
    logic        sti_rd;
    logic [9:0]  sti_addr;
    logic [15:0] sti_di;
    logic        res_wr;
    logic [13:0] res_addr;
    logic [7:0]  res_do;
`ifdef FG_COUNT_EN
    logic [13:0] fg_cnt;
`endif

    sti_loader dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .busy     (busy),
        .done     (done),
        .sti_rd   (sti_rd),
        .sti_addr (sti_addr),
        .sti_di   (sti_di),
        .res_wr   (res_wr),
        .res_addr (res_addr),
        .res_do   (res_do)
`ifdef FG_COUNT_EN
        ,
        .fg_cnt   (fg_cnt)
`endif
    );

    // ---------------- clock / reset ----------------
    int cyc;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc = cyc + 1;
        end
    end

    // ---------------- ROM model ----------------
    logic [15:0] rom [1024];

    initial begin
        sti_di = 16'd0;
        forever begin
            @(negedge clk);
            if (sti_rd) sti_di = rom[sti_addr];
        end
    end

    // ---------------- scoreboard ----------------
    logic [21:0] exp_q [$];   // {pixel address, pixel byte}
    logic [9:0]  rd_q  [$];   // expected ROM word addresses
    int          checks;
    int          errors;
    int          exp_fg;
    logic        mon_en;

    // Reference model: pixel p sits at row p/128, column p%128 and comes
    // from bit (15 - p%16) of ROM word p/16; border pixels are zero.
    task automatic push_load();
        logic [15:0] v;
        logic        b;
        int          row;
        int          col;
        logic [13:0] a;
        exp_fg = 0;
        for (int p = 0; p < 16384; p++) begin
            row = p / 128;
            col = p % 128;
            v   = rom[p / 16];
            b   = v[15 - (p % 16)];
            if (row == 0 || row == 127 || col == 0 || col == 127) b = 1'b0;
            a = p[13:0];
            exp_q.push_back({a, 7'd0, b});
            if (b) exp_fg = exp_fg + 1;
        end
        for (int wd = 0; wd < 1024; wd++) rd_q.push_back(wd[9:0]);
    endtask

    // Monitor: every cycle, protocol rules plus pop-and-compare of strobes.
    initial begin
        logic [21:0] e;
        logic [9:0]  ea;
        forever begin
            @(negedge clk);
            if (reset && mon_en) begin
                checks = checks + 1;
                if ((sti_rd && res_wr) || (res_do > 8'h01) ||
                    ((sti_rd || res_wr) && !busy)) begin
                    errors = errors + 1;
                    $display("FAIL protocol cyc=%0d sti_rd=%0b res_wr=%0b busy=%0b res_do=%h",
                             cyc, sti_rd, res_wr, busy, res_do);
                end
                if (res_wr) begin
                    checks = checks + 1;
                    if (exp_q.size() == 0) begin
                        errors = errors + 1;
                        $display("FAIL unexpected_write cyc=%0d addr=%0d data=%h required=none",
                                 cyc, res_addr, res_do);
                    end else begin
                        e = exp_q.pop_front();
                        if ({res_addr, res_do} !== e) begin
                            errors = errors + 1;
                            $display("FAIL pixel_write cyc=%0d got addr=%0d data=%h required addr=%0d data=%h",
                                     cyc, res_addr, res_do, e[21:8], e[7:0]);
                        end
                    end
                end
                if (sti_rd) begin
                    checks = checks + 1;
                    if (rd_q.size() == 0) begin
                        errors = errors + 1;
                        $display("FAIL unexpected_read cyc=%0d addr=%0d required=none", cyc, sti_addr);
                    end else begin
                        ea = rd_q.pop_front();
                        if (sti_addr !== ea) begin
                            errors = errors + 1;
                            $display("FAIL rom_addr cyc=%0d got=%0d required=%0d", cyc, sti_addr, ea);
                        end
                    end
                end
            end
        end
    end

    // ---------------- driver / check tasks ----------------
    task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
        checks = checks + 1;
        if (got !== req) begin
            errors = errors + 1;
            $display("FAIL %s got=%0d required=%0d", name, got, req);
        end
    endtask

    // Issue start on a quiet cycle; returns the cycle in which busy is first high.
    task automatic issue_start(input bit hold, output int c0);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        c0 = cyc;
        check("busy_after_start", {31'd0, busy}, 32'd1);
        check("done_cleared_on_start", {31'd0, done}, 32'd0);
        if (!hold) start = 1'b0;
    endtask

    // Wait (bounded) for done, optionally pulsing start at cycle extra_at.
    task automatic wait_done(input int c0, input int extra_at);
        bit seen;
        int lat;
        seen = 1'b0;
        for (int n = 1; n <= 17600; n++) begin
            @(negedge clk);
            if (n == extra_at) start = 1'b1;
            else if (n == extra_at + 1) start = 1'b0;
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        check("done_seen", {31'd0, seen}, 32'd1);
        lat = cyc - c0;
        checks = checks + 1;
        if (lat < 17406 || lat > 17410) begin
            errors = errors + 1;
            $display("FAIL load_latency got=%0d required=17408", lat);
        end
        check("busy_low_at_done", {31'd0, busy}, 32'd0);
        check("writes_left", exp_q.size(), 32'd0);
        check("reads_left", rd_q.size(), 32'd0);
`ifdef FG_COUNT_EN
        check("fg_cnt", {18'd0, fg_cnt}, exp_fg);
`endif
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int c0;
        checks = 0;
        errors = 0;
        exp_fg = 0;
        mon_en = 1'b1;
        reset  = 1'b0;
        start  = 1'b0;
        for (int i = 0; i < 1024; i++) rom[i] = 16'h0000;

        repeat (3) @(negedge clk);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_sti_rd", {31'd0, sti_rd}, 32'd0);
        check("rst_res_wr", {31'd0, res_wr}, 32'd0);
        check("rst_sti_addr", {22'd0, sti_addr}, 32'd0);
        check("rst_res_addr", {18'd0, res_addr}, 32'd0);
        check("rst_res_do", {24'd0, res_do}, 32'd0);
`ifdef FG_COUNT_EN
        check("rst_fg_cnt", {18'd0, fg_cnt}, 32'd0);
`endif
        reset = 1'b1;
        repeat (5) @(negedge clk);
        check("idle_after_reset", {30'd0, busy, sti_rd}, 32'd0);

        // Load 1: single word 16'h8001 at word 8, stray start at cycle 100.
        rom[8] = 16'h8001;
        push_load();
        issue_start(1'b0, c0);
        wait_done(c0, 100);

        // Load 2: all ones, start held high so load 3 follows automatically.
        for (int i = 0; i < 1024; i++) rom[i] = 16'hFFFF;
        push_load();
        issue_start(1'b1, c0);
        wait_done(c0, -10);
        // Load 3 gets random data; ROM reads for it begin two cycles later.
        for (int i = 0; i < 1024; i++) rom[i] = $urandom_range(0, 65535);
        push_load();
        @(negedge clk);
        check("idle_done_held", {31'd0, done}, 32'd1);
        check("idle_busy_low", {31'd0, busy}, 32'd0);
        @(negedge clk);
        c0 = cyc;
        check("restart_busy", {31'd0, busy}, 32'd1);
        check("restart_done_clr", {31'd0, done}, 32'd0);
        start = 1'b0;
        wait_done(c0, -10);

        // Load 4: random data, aborted by reset at cycle 5000.
        for (int i = 0; i < 1024; i++) rom[i] = $urandom_range(0, 65535);
        push_load();
        repeat (2) @(negedge clk);
        issue_start(1'b0, c0);
        repeat (5000) @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_sti_rd", {31'd0, sti_rd}, 32'd0);
        check("abort_res_wr", {31'd0, res_wr}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        exp_q.delete();
        rd_q.delete();
        repeat (3) @(negedge clk);
        reset = 1'b1;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            check("post_reset_idle", {30'd0, busy, done}, 32'd0);
        end
`ifdef FG_COUNT_EN
        check("post_reset_fg", {18'd0, fg_cnt}, 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
